// File: rtl/boot_loader.sv
// Serial boot loader: copies a received byte stream into program RAM from
// address 0, holding boot high until the RAM is full or the stream goes idle.
module boot_loader #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 65535,
  parameter int unsigned TO_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              boot,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_enable,
  output logic              mem_we,
  output logic              done,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRITE = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [TO_W-1:0]   idle, idle_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] data_next;
  logic [ADDR_W:0]   count_next;
  logic              done_next;

  // State and datapath registers; everything holds while ce is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      idle       <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      byte_count <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      idle       <= idle_next;
      mem_addr   <= addr_next;
      mem_data   <= data_next;
      byte_count <= count_next;
      done       <= done_next;
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_next = state;
    idle_next  = idle;
    addr_next  = mem_addr;
    data_next  = mem_data;
    count_next = byte_count;
    done_next  = done;
    if (ce) begin
      done_next = 1'b0;
      case (state)
        LOAD: begin
          if (rx_valid) begin
            data_next  = rx_data;
            idle_next  = '0;
            state_next = WRITE;
          end else if (byte_count != '0) begin
            // Idle timer only runs once the first byte has arrived
            idle_next = idle + TO_W'(1);
            if (idle_next == TO_W'(TIMEOUT)) begin
              state_next = RUN;
              done_next  = 1'b1;
            end
          end
        end
        WRITE: begin
          count_next = byte_count + (ADDR_W + 1)'(1);
          // Address wraps to 0 naturally after the last location
          addr_next  = mem_addr + ADDR_W'(1);
          if (mem_addr == '1) begin
            state_next = RUN;
            done_next  = 1'b1;
          end else begin
            state_next = LOAD;
          end
        end
        RUN: begin
          if (start) begin
            state_next = LOAD;
            addr_next  = '0;
            count_next = '0;
            idle_next  = '0;
          end
        end
        default: state_next = LOAD;
      endcase
    end
  end

  // Bus control decoded straight from state
  always_comb begin
    boot       = (state != RUN);
    rx_ready   = (state == LOAD);
    mem_enable = (state == WRITE);
    mem_we     = (state == WRITE);
  end

endmodule
